// File: rtl/microwave_pkg.sv
// Shared types and constants for the oven sequencer: FSM states, BCD limits
// and the 3-digit M:SS cook-time record with its countdown helper.
package microwave_pkg;

   typedef enum logic [1:0] {IDLE, COOK, PAUSE, DONE} state_t;

   localparam logic [3:0] BCD_MAX_DIGIT   = 4'd9;
   localparam logic [3:0] SEC_TENS_RELOAD = 4'd5;

   typedef struct packed {
      logic [3:0] min_ones;
      logic [3:0] sec_tens;
      logic [3:0] sec_ones;
   } cook_time_t;

   localparam cook_time_t ZERO_TIME = cook_time_t'(12'h000);
   localparam cook_time_t ONE_SEC   = cook_time_t'(12'h001);

   // Entered sec_tens above 5 simply counts down through 5 like any other digit.
   function automatic cook_time_t bcd_decrement(input cook_time_t t);
      cook_time_t r;
      r = t;
      if (t.sec_ones != 4'd0) begin
         r.sec_ones = t.sec_ones - 4'd1;
      end else if (t.sec_tens != 4'd0) begin
         r.sec_tens = t.sec_tens - 4'd1;
         r.sec_ones = BCD_MAX_DIGIT;
      end else if (t.min_ones != 4'd0) begin
         r.min_ones = t.min_ones - 4'd1;
         r.sec_tens = SEC_TENS_RELOAD;
         r.sec_ones = BCD_MAX_DIGIT;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_timer.sv
// Three-digit BCD cook-time register: clear, shift-in of a keyed digit, and
// one-second countdown that never wraps below 0:00.
module bcd_timer
   import microwave_pkg::*;
(
   input  logic       clk,
   input  logic       clearn,
   input  logic       clear,
   input  logic       shift,
   input  logic       dec,
   input  logic [3:0] digit,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       is_zero
);

   cook_time_t cur_time;
   cook_time_t shift_base;

   // clear together with shift means "start a fresh entry with this digit"
   always_comb begin
      shift_base = clear ? ZERO_TIME : cur_time;
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!clearn) begin
         cur_time <= ZERO_TIME;
      end else if (shift) begin
         cur_time <= cook_time_t'({shift_base.sec_tens, shift_base.sec_ones, digit});
      end else if (clear) begin
         cur_time <= ZERO_TIME;
      end else if (dec && !is_zero) begin
         cur_time <= bcd_decrement(cur_time);
      end
   end

   assign min_ones = cur_time.min_ones;
   assign sec_tens = cur_time.sec_tens;
   assign sec_ones = cur_time.sec_ones;
   assign is_zero  = (cur_time == ZERO_TIME);

endmodule

// File: rtl/microwave_controller.sv
// Oven sequencing FSM: captures keyed digits while idle, runs the magnetron
// and counts down on the 1 Hz tick, with stop/pause/clear and door interlock.
module microwave_controller
   import microwave_pkg::*;
(
   input  logic       clk,
   input  logic       clearn,
   input  logic [3:0] D,
   input  logic       loadn,
   input  logic       pgt_1Hz,
   input  logic       startn,
   input  logic       stopn,
   input  logic       door_closed,
   output logic       enable,
   output logic       mag_on,
   output logic       done,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones
);

   state_t state;
   state_t state_next;
   logic   loadn_prev;
   logic   capture;
   logic   last_second;
   logic   is_zero;
   logic   tmr_clear;
   logic   tmr_shift;
   logic   tmr_dec;

   assign capture     = !loadn && loadn_prev && (D <= BCD_MAX_DIGIT);
   assign last_second = (cook_time_t'({min_ones, sec_tens, sec_ones}) == ONE_SEC);

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      tmr_clear  = 1'b0;
      tmr_shift  = 1'b0;
      tmr_dec    = 1'b0;
      case (state)
         IDLE: begin
            if (!stopn) begin
               tmr_clear = 1'b1;
            end else begin
               tmr_shift = capture;
               if (!startn && door_closed && !is_zero) state_next = COOK;
            end
         end
         COOK: begin
            // stop and door-open both pre-empt a coincident tick
            if (!stopn || !door_closed) begin
               state_next = PAUSE;
            end else if (pgt_1Hz) begin
               tmr_dec = 1'b1;
               if (last_second) state_next = DONE;
            end
         end
         PAUSE: begin
            if (!stopn) begin
               tmr_clear  = 1'b1;
               state_next = IDLE;
            end else if (!startn && door_closed) begin
               state_next = COOK;
            end
         end
         DONE: begin
            if (!stopn) begin
               state_next = IDLE;
            end else if (capture) begin
               tmr_clear  = 1'b1;
               tmr_shift  = 1'b1;
               state_next = IDLE;
            end else if (!startn) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered alongside it.
   always_ff @(posedge clk) begin
      if (!clearn) begin
         state      <= IDLE;
         loadn_prev <= 1'b1;
         enable     <= 1'b1;
         mag_on     <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_next;
         loadn_prev <= loadn;
         enable     <= (state_next == IDLE) || (state_next == DONE);
         mag_on     <= (state_next == COOK);
         done       <= (state_next == DONE);
      end
   end

   bcd_timer u_timer (
      .clk      (clk),
      .clearn   (clearn),
      .clear    (tmr_clear),
      .shift    (tmr_shift),
      .dec      (tmr_dec),
      .digit    (D),
      .min_ones (min_ones),
      .sec_tens (sec_tens),
      .sec_ones (sec_ones),
      .is_zero  (is_zero)
   );

endmodule

// File: tb/tb_microwave_controller.sv
// Self-checking bench: directed oven scenarios then randomized key/door/tick
// traffic, all compared each cycle against a minutes/seconds reference model.
module tb_microwave_controller;

   logic       clk;
   logic       clearn;
   logic [3:0] D;
   logic       loadn;
   logic       pgt_1Hz;
   logic       startn;
   logic       stopn;
   logic       door_closed;
   logic       enable;
   logic       mag_on;
   logic       done;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;

   int n_checks = 0;
   int n_fail   = 0;

   localparam int M_IDLE  = 0;
   localparam int M_COOK  = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   // reference: whole minutes plus a 0..99 seconds field (tens may exceed 5 when keyed)
   int mode;
   int mins;
   int secs;
   bit m_loadn_prev;

   microwave_controller dut (
      .clk         (clk),
      .clearn      (clearn),
      .D           (D),
      .loadn       (loadn),
      .pgt_1Hz     (pgt_1Hz),
      .startn      (startn),
      .stopn       (stopn),
      .door_closed (door_closed),
      .enable      (enable),
      .mag_on      (mag_on),
      .done        (done),
      .min_ones    (min_ones),
      .sec_tens    (sec_tens),
      .sec_ones    (sec_ones)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [14:0] model_outs();
      logic en, mg, dn;
      en = (mode == M_IDLE) || (mode == M_DONE);
      mg = (mode == M_COOK);
      dn = (mode == M_DONE);
      return {en, mg, dn, 4'(mins), 4'(secs / 10), 4'(secs % 10)};
   endfunction

   task automatic shift_in(input int d);
      mins = secs / 10;
      secs = (secs % 10) * 10 + d;
   endtask

   task automatic model_edge();
      bit cap;
      bit go;
      cap = !loadn && m_loadn_prev && (D <= 4'd9) && (mode == M_IDLE || mode == M_DONE);
      if (!clearn) begin
         mode = M_IDLE; mins = 0; secs = 0; m_loadn_prev = 1'b1;
         return;
      end
      case (mode)
         M_IDLE: begin
            if (!stopn) begin
               mins = 0; secs = 0;
            end else begin
               go = !startn && door_closed && (mins != 0 || secs != 0);
               if (cap) shift_in(int'(D));
               if (go) mode = M_COOK;
            end
         end
         M_COOK: begin
            if (!stopn || !door_closed) begin
               mode = M_PAUSE;
            end else if (pgt_1Hz) begin
               if (secs > 0) secs--;
               else if (mins > 0) begin mins--; secs = 59; end
               if (mins == 0 && secs == 0) mode = M_DONE;
            end
         end
         M_PAUSE: begin
            if (!stopn) begin
               mins = 0; secs = 0; mode = M_IDLE;
            end else if (!startn && door_closed) begin
               mode = M_COOK;
            end
         end
         default: begin
            if (!stopn) mode = M_IDLE;
            else if (cap) begin mins = 0; secs = int'(D); mode = M_IDLE; end
            else if (!startn) mode = M_IDLE;
         end
      endcase
      m_loadn_prev = loadn;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("outs", {enable, mag_on, done, min_ones, sec_tens, sec_ones}, model_outs());
   endtask

   task automatic idle_inputs();
      clearn = 1'b1; loadn = 1'b1; D = 4'd0; pgt_1Hz = 1'b0;
      startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
   endtask

   task automatic key(input logic [3:0] d);
      loadn = 1'b0; D = d; cycle();
      loadn = 1'b1; cycle();
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         pgt_1Hz = 1'b1; cycle();
         pgt_1Hz = 1'b0; cycle();
      end
   endtask

   task automatic press_start();
      startn = 1'b0; cycle(); startn = 1'b1;
   endtask

   task automatic press_stop();
      stopn = 1'b0; cycle(); stopn = 1'b1;
   endtask

   initial begin
      idle_inputs();
      mode = M_IDLE; mins = 0; secs = 0; m_loadn_prev = 1'b1;

      clearn = 1'b0; cycle(); cycle();
      check("reset", {enable, mag_on, done, min_ones, sec_tens, sec_ones}, {3'b100, 12'h000});
      clearn = 1'b1;

      key(4'd1); key(4'd0); key(4'd5);
      check("key_105", {min_ones, sec_tens, sec_ones}, 12'h105);
      check("idle_en", {enable, mag_on}, 2'b10);
      key(4'd12);
      check("key_bad", {min_ones, sec_tens, sec_ones}, 12'h105);

      press_start();
      check("start_mag", mag_on, 1'b1);
      tick(6);
      check("t_059", {min_ones, sec_tens, sec_ones}, 12'h059);
      tick(59);
      check("t_000", {min_ones, sec_tens, sec_ones}, 12'h000);
      check("done_outs", {enable, mag_on, done}, 3'b101);
      press_stop();
      check("done_stop", {enable, mag_on, done}, 3'b100);

      press_start();
      check("zero_start", {enable, mag_on}, 2'b10);
      key(4'd3); key(4'd0);
      door_closed = 1'b0;
      press_start();
      check("door_start", {enable, mag_on, min_ones, sec_tens, sec_ones}, {2'b10, 12'h030});
      door_closed = 1'b1;

      press_stop();
      key(4'd2); key(4'd0);
      press_start();
      door_closed = 1'b0; pgt_1Hz = 1'b1; cycle(); pgt_1Hz = 1'b0;
      check("door_pause", {enable, mag_on, min_ones, sec_tens, sec_ones}, {2'b00, 12'h020});
      door_closed = 1'b1;
      press_start();
      check("resume", {mag_on, min_ones, sec_tens, sec_ones}, {1'b1, 12'h020});
      press_stop();
      check("cook_stop", {enable, mag_on, min_ones, sec_tens, sec_ones}, {2'b00, 12'h020});
      press_stop();
      check("pause_clr", {enable, mag_on, min_ones, sec_tens, sec_ones}, {2'b10, 12'h000});

      key(4'd1);
      press_start();
      stopn = 1'b0; pgt_1Hz = 1'b1; cycle(); stopn = 1'b1; pgt_1Hz = 1'b0;
      check("stop_tick", {mag_on, done, min_ones, sec_tens, sec_ones}, {2'b00, 12'h001});
      press_stop();

      key(4'd1); key(4'd0); key(4'd0);
      press_start();
      check("cook_100", {mag_on, min_ones, sec_tens, sec_ones}, {1'b1, 12'h100});
      clearn = 1'b0; cycle(); clearn = 1'b1;
      check("clr_cook", {enable, mag_on, done, min_ones, sec_tens, sec_ones}, {3'b100, 12'h000});
      loadn = 1'b0; D = 4'd7;
      for (int i = 0; i < 5; i++) cycle();
      loadn = 1'b1; cycle();
      check("held_load", {min_ones, sec_tens, sec_ones}, 12'h007);

      for (int i = 0; i < 4000; i++) begin
         clearn      = ($urandom_range(0, 299) != 0);
         loadn       = ($urandom_range(0, 3) != 0);
         D           = 4'($urandom_range(0, 15));
         startn      = ($urandom_range(0, 5) != 0);
         stopn       = ($urandom_range(0, 24) != 0);
         door_closed = ($urandom_range(0, 9) != 0);
         pgt_1Hz     = ($urandom_range(0, 1) != 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
